video_mono_packer: RTL and testbench

Upstream feeder for the I2S mono video transmitter: converts the 24-bit RGB pixel stream into 8-bit luma and packs two pixels per 16-bit I2S sample. It marks frame boundaries and buffers samples in a small FIFO. The transmitter drains the FIFO through a valid/ready handshake, gated by the host clear-to-send.

---
 rtl/video_mono_packer.sv | 147 ++++++++++++++
 tb/tb_video_mono_packer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mono_packer.sv
// RGB pixel stream to 8-bit luma, packed two pixels per 16-bit sample,
// frame-marked and buffered in a show-ahead FIFO with a cts-gated drain.
module video_mono_packer #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          pclk,
   input  logic          reset_n,
   input  logic [23:0]   disp_data,
   input  logic          datavalid,
   input  logic          v_sync,
   input  logic          cts,
   output logic [15:0]   sample_data,
   output logic          sample_sof,
   output logic          sample_valid,
   input  logic          sample_ready,
   output logic [AW:0]   fill_level,
   output logic          overflow
);

   typedef enum logic {EMPTY, HALF} pack_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [1:0]  rst_sync;
   logic        rst_s;
   logic [10:0] sum;
   logic [7:0]  y;
   logic [7:0]  s1_y;
   logic        s1_vld;
   logic        s1_bnd;
   logic        vs_q;
   pack_t       state;
   logic [7:0]  hi;
   logic        hi_sof;
   logic        pend_sof;
   logic        push_q;
   logic [16:0] push_w;
   logic [16:0] mem [DEPTH];
   logic [16:0] head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0] count;
   logic        full;
   logic        empty;
   logic        pop;
   logic        wr_en;

   // assert immediately, release two pclk edges later
   always_ff @(posedge pclk or negedge reset_n)
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};

   assign rst_s = rst_sync[1];

   assign sum = {2'b00, disp_data[23:16], 1'b0}
              + {1'b0, disp_data[15:8], 2'b00}
              + {3'b000, disp_data[15:8]}
              + {3'b000, disp_data[7:0]};
   assign y   = 8'(sum >> 3);

   always_ff @(posedge pclk or negedge rst_s)
      if (!rst_s) begin
         s1_y   <= '0;
         s1_vld <= 1'b0;
         s1_bnd <= 1'b0;
         vs_q   <= 1'b1;
      end else begin
         s1_y   <= y;
         s1_vld <= datavalid;
         s1_bnd <= v_sync & ~vs_q;
         vs_q   <= v_sync;
      end

   // a boundary flushes a half word as a pad before the new frame starts
   always_ff @(posedge pclk or negedge rst_s)
      if (!rst_s) begin
         state    <= EMPTY;
         hi       <= '0;
         hi_sof   <= 1'b0;
         pend_sof <= 1'b0;
         push_q   <= 1'b0;
         push_w   <= '0;
      end else begin
         push_q <= 1'b0;
         if (s1_bnd) begin
            if (state == HALF) begin
               push_q <= 1'b1;
               push_w <= {hi_sof, hi, 8'h00};
            end
            if (s1_vld) begin
               hi       <= s1_y;
               hi_sof   <= 1'b1;
               pend_sof <= 1'b0;
               state    <= HALF;
            end else begin
               pend_sof <= 1'b1;
               state    <= EMPTY;
            end
         end else if (s1_vld) begin
            unique case (state)
               EMPTY: begin
                  hi       <= s1_y;
                  hi_sof   <= pend_sof;
                  pend_sof <= 1'b0;
                  state    <= HALF;
               end
               HALF: begin
                  push_q <= 1'b1;
                  push_w <= {hi_sof, hi, s1_y};
                  state  <= EMPTY;
               end
            endcase
         end
      end

   assign full         = count == FULL;
   assign empty        = count == '0;
   assign sample_valid = cts & ~empty;
   assign pop          = sample_valid & sample_ready;
   assign wr_en        = push_q & (~full | pop);
   assign head         = mem[rd_ptr];
   assign sample_data  = empty ? 16'h0000 : head[15:0];
   assign sample_sof   = ~empty & head[16];
   assign fill_level   = count;

   always_ff @(posedge pclk)
      if (wr_en) mem[wr_ptr] <= push_w;

   always_ff @(posedge pclk or negedge rst_s)
      if (!rst_s) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_en, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (push_q & full & ~pop) overflow <= 1'b1;
      end

endmodule

// File: tb/tb_video_mono_packer.sv
// Bench for video_mono_packer: frame-indexed packing model plus
// directed scenarios with hand-computed words.
module tb_video_mono_packer;

   localparam int DEPTH = 16;

   logic        pclk = 1'b0;
   logic        reset_n;
   logic [23:0] disp_data;
   logic        datavalid;
   logic        v_sync;
   logic        cts;
   logic [15:0] sample_data;
   logic        sample_sof;
   logic        sample_valid;
   logic        sample_ready;
   logic [4:0]  fill_level;
   logic        overflow;

   video_mono_packer #(.DEPTH(DEPTH)) dut (
      .pclk(pclk),
      .reset_n(reset_n),
      .disp_data(disp_data),
      .datavalid(datavalid),
      .v_sync(v_sync),
      .cts(cts),
      .sample_data(sample_data),
      .sample_sof(sample_sof),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .fill_level(fill_level),
      .overflow(overflow)
   );

   always #5 pclk = ~pclk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   logic [16:0] q[$];
   bit          movf;
   bit          st1_v, st2_v;
   logic [16:0] st1_w, st2_w;
   bit          vs_prev;
   int          idx;
   bit          started;
   logic [7:0]  m_hi;
   bit          m_hisof;
   logic [16:0] h;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   function automatic logic [7:0] luma(input logic [23:0] p);
      int s;
      s = 2 * int'(p[23:16]) + 5 * int'(p[15:8]) + int'(p[7:0]);
      return 8'(s / 8);
   endfunction

   function automatic logic [23:0] gray(input int v);
      logic [7:0] b;
      b = 8'(v);
      return {b, b, b};
   endfunction

   task automatic model_reset();
      q.delete();
      movf    = 1'b0;
      st1_v   = 1'b0;
      st2_v   = 1'b0;
      st1_w   = '0;
      st2_w   = '0;
      vs_prev = 1'b1;
      idx     = 0;
      started = 1'b0;
      m_hi    = '0;
      m_hisof = 1'b0;
   endtask

   // words are formed by pixel position within the current frame
   task automatic model_edge();
      bit          pv;
      logic [16:0] w;
      if (!reset_n) return;
      if (cts && sample_ready && q.size() > 0) void'(q.pop_front());
      if (st2_v) begin
         if (q.size() < DEPTH) q.push_back(st2_w);
         else movf = 1'b1;
      end
      st2_v = st1_v;
      st2_w = st1_w;
      pv = 1'b0;
      w  = '0;
      if (v_sync && !vs_prev) begin
         if (idx % 2 == 1) begin
            pv = 1'b1;
            w  = {m_hisof, m_hi, 8'h00};
         end
         idx     = 0;
         started = 1'b1;
      end
      vs_prev = v_sync;
      if (datavalid) begin
         if (idx % 2 == 0) begin
            m_hi    = luma(disp_data);
            m_hisof = started && idx == 0;
         end else begin
            pv = 1'b1;
            w  = {m_hisof, m_hi, luma(disp_data)};
         end
         idx++;
      end
      st1_v = pv;
      st1_w = w;
   endtask

   always @(negedge pclk) begin
      if (chk_en) begin
         chk("valid", sample_valid, cts && q.size() > 0);
         chk("fill", fill_level, q.size());
         chk("ovf", overflow, movf);
         if (q.size() > 0) begin
            h = q[0];
            chk("data", sample_data, h[15:0]);
            chk("sof", sample_sof, h[16]);
         end else begin
            chk("data_empty", sample_data, 0);
            chk("sof_empty", sample_sof, 0);
         end
      end
   end

   task automatic tick();
      @(posedge pclk);
      model_edge();
      #1;
   endtask

   task automatic px(input logic [23:0] d, input bit v, input bit vs);
      disp_data = d;
      datavalid = v;
      v_sync    = vs;
      tick();
   endtask

   task automatic pop_word(input logic [15:0] d, input bit s);
      int n;
      n = 0;
      datavalid = 1'b0;
      v_sync    = 1'b0;
      while (!sample_valid && n < 20) begin
         tick();
         n++;
      end
      if (!sample_valid) begin
         chk("pop_timeout", 0, 1);
      end else begin
         chk("pop_data", sample_data, d);
         chk("pop_sof", sample_sof, s);
         sample_ready = 1'b1;
         tick();
         sample_ready = 1'b0;
      end
   endtask

   task automatic do_reset();
      tick();
      #2;
      reset_n      = 1'b0;
      model_reset();
      disp_data    = '0;
      datavalid    = 1'b0;
      v_sync       = 1'b0;
      sample_ready = 1'b0;
      #1;
      chk("rst_valid", sample_valid, 0);
      chk("rst_data", sample_data, 0);
      chk("rst_sof", sample_sof, 0);
      chk("rst_fill", fill_level, 0);
      chk("rst_ovf", overflow, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      reset_n      = 1'b1;
      disp_data    = '0;
      datavalid    = 1'b0;
      v_sync       = 1'b0;
      cts          = 1'b1;
      sample_ready = 1'b0;
      model_reset();
      #2 reset_n = 1'b0;
      tick();
      tick();
      chk_en = 1'b1;
      chk("init_valid", sample_valid, 0);
      chk("init_data", sample_data, 0);
      chk("init_fill", fill_level, 0);
      chk("init_ovf", overflow, 0);
      reset_n = 1'b1;
      repeat (4) tick();

      chk("model_luma_a", luma(24'h8fff7f), 8'hD3);
      chk("model_luma_b", luma(24'hffffff), 8'hFF);

      // frame start, one pair, latency to sample_valid
      px(24'h0, 1'b0, 1'b1);
      px(24'h8fff7f, 1'b1, 1'b0);
      px(24'hffffff, 1'b1, 1'b0);
      px(24'h0, 1'b0, 1'b0);
      chk("t1_lat1", sample_valid, 0);
      px(24'h0, 1'b0, 1'b0);
      chk("t1_lat2", sample_valid, 1);
      chk("t1_word", sample_data, 16'hD3FF);
      pop_word(16'hD3FF, 1'b1);

      // odd pixel count then boundary pads the half word
      px(24'h0, 1'b0, 1'b1);
      repeat (3) px(24'h000000, 1'b1, 1'b0);
      px(24'h0, 1'b0, 1'b1);
      px(24'h404040, 1'b1, 1'b0);
      px(24'h505050, 1'b1, 1'b0);
      pop_word(16'h0000, 1'b1);
      pop_word(16'h0000, 1'b0);
      pop_word(16'h4050, 1'b1);

      // pixel coincident with boundary while half full
      px(24'h111111, 1'b1, 1'b0);
      px(24'h222222, 1'b1, 1'b1);
      px(24'h333333, 1'b1, 1'b0);
      pop_word(16'h1100, 1'b0);
      pop_word(16'h2233, 1'b1);

      // cts low: fill, overflow, then ordered drain
      cts = 1'b0;
      for (int i = 0; i < 2 * DEPTH + 2; i++) px(gray(i * 7 + 1), 1'b1, 1'b0);
      repeat (4) px(24'h0, 1'b0, 1'b0);
      chk("t4_valid", sample_valid, 0);
      chk("t4_fill", fill_level, DEPTH);
      chk("t4_ovf", overflow, 1);
      cts = 1'b1;
      sample_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         chk("t4_drain", sample_data,
             {8'(14 * k + 1), 8'(14 * k + 8)});
         px(24'h0, 1'b0, 1'b0);
      end
      chk("t4_empty", fill_level, 0);
      sample_ready = 1'b0;

      do_reset();

      // full FIFO with simultaneous pop and push
      cts = 1'b0;
      for (int i = 0; i < 2 * DEPTH + 6; i++) begin
         cts          = st2_v && q.size() == DEPTH;
         sample_ready = cts;
         if (i < 2 * DEPTH + 2) px(gray(i + 1), 1'b1, 1'b0);
         else px(24'h0, 1'b0, 1'b0);
      end
      cts          = 1'b0;
      sample_ready = 1'b0;
      #1;
      chk("t5_fill", fill_level, DEPTH);
      chk("t5_ovf", overflow, 0);
      chk("t5_head", sample_data, 16'h0304);
      cts          = 1'b1;
      sample_ready = 1'b1;
      repeat (DEPTH + 4) px(24'h0, 1'b0, 1'b0);
      sample_ready = 1'b0;

      // reset mid-stream loses the half word
      repeat (3) px(24'h111111, 1'b1, 1'b0);
      repeat (3) px(24'h0, 1'b0, 1'b0);
      chk("t6_pre", sample_valid, 1);
      do_reset();
      px(24'h555555, 1'b1, 1'b0);
      px(24'h666666, 1'b1, 1'b0);
      px(24'h0, 1'b0, 1'b1);
      px(24'h777777, 1'b1, 1'b0);
      px(24'h888888, 1'b1, 1'b0);
      pop_word(16'h5566, 1'b0);
      pop_word(16'h7788, 1'b1);
      repeat (3) px(24'h0, 1'b0, 1'b0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
